// File: rtl/stream_pkg.sv
// Shared definitions for the byte-stream receive path: byte width, packer state
// encoding and the keep-mask helper.
package stream_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } stream_rx_state_e;

  // Lanes 0..count-1 set; count ranges 0..8.
  function automatic logic [7:0] keep_from_count(input logic [3:0] count);
    logic [7:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (4'(i) < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_rx_stats.sv
// Saturating word and frame transfer counters for stream_rx; only built
// when STREAM_RX_STATS_EN is defined.
module stream_rx_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        xfer,
  input  logic        xfer_last,
  output logic [15:0] word_count,
  output logic [15:0] frame_count
);

  logic [15:0] word_count_q, word_count_d;
  logic [15:0] frame_count_q, frame_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      word_count_q  <= word_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    word_count_d  = word_count_q;
    frame_count_d = frame_count_q;
    if (xfer && (word_count_q != 16'hFFFF)) begin
      word_count_d = word_count_q + 16'd1;
    end
    if (xfer && xfer_last && (frame_count_q != 16'hFFFF)) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  assign word_count  = word_count_q;
  assign frame_count = frame_count_q;

endmodule

// File: rtl/stream_rx.sv
// Byte-to-word little-endian packer with valid/ready on both sides and
// last-byte flush. Define STREAM_RX_STATS_EN to add word/frame counters.
module stream_rx
  import stream_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int WORD_W         = 8 * BYTES_PER_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BYTE_W-1:0]         data_in,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [WORD_W-1:0]         data_out,
  output logic [BYTES_PER_WORD-1:0] out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef STREAM_RX_STATS_EN
  ,
  output logic [15:0]               word_count,
  output logic [15:0]               frame_count
`endif
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);

  stream_rx_state_e          state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WORD_W-1:0]         acc_q, acc_d;
  logic [WORD_W-1:0]         data_q, data_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;

  logic                      accept;
  logic                      commit;
  logic [WORD_W-1:0]         acc_wr;

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every target gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;

    accept = in_valid && in_ready;
    commit = accept && ((idx_q == LAST_LANE) || in_last);

    acc_wr = acc_q;
    acc_wr[int'(idx_q) * BYTE_W +: BYTE_W] = data_in;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (commit) begin
      // Accumulator is zero above idx, so unfilled lanes of a flush read 0.
      data_d  = acc_wr;
      keep_d  = BYTES_PER_WORD'(keep_from_count(4'(idx_q) + 4'd1));
      last_d  = in_last;
      valid_d = 1'b1;
      idx_d   = '0;
      acc_d   = '0;
      state_d = IDLE;
    end else if (accept) begin
      acc_d   = acc_wr;
      idx_d   = idx_q + 1'b1;
      state_d = FILL;
    end
  end

  always_comb begin
    in_ready  = !valid_q || out_ready;
    data_out  = data_q;
    out_keep  = keep_q;
    out_last  = last_q;
    out_valid = valid_q;
  end

`ifdef STREAM_RX_STATS_EN
  stream_rx_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .xfer        (valid_q && out_ready),
    .xfer_last   (last_q),
    .word_count  (word_count),
    .frame_count (frame_count)
  );
`endif

endmodule

// File: tb/tb_stream_rx.sv
// Directed bench for stream_rx: a byte-level model pushes expected words to a
// scoreboard queue, a negedge monitor pops and compares each transferred word.
module tb_stream_rx;

  localparam int BPW    = 4;
  localparam int WORD_W = 8 * BPW;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [BPW-1:0]    keep;
    logic              last;
  } word_t;

  logic              clk;
  logic              rst;
  logic [7:0]        data_in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [WORD_W-1:0] data_out;
  logic [BPW-1:0]    out_keep;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
`ifdef STREAM_RX_STATS_EN
  logic [15:0]       word_count;
  logic [15:0]       frame_count;
`endif

  stream_rx #(.BYTES_PER_WORD(BPW)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .out_keep    (out_keep),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef STREAM_RX_STATS_EN
    ,
    .word_count  (word_count),
    .frame_count (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  word_t sb_q[$];

  logic [WORD_W-1:0] m_acc;
  int                m_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_n   = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic last);
    word_t w;
    m_acc[8*m_n +: 8] = b;
    m_n++;
    if (m_n == BPW || last) begin
      w.data = m_acc;
      w.keep = BPW'((1 << m_n) - 1);
      w.last = last;
      sb_q.push_back(w);
      model_reset();
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the byte.
  task automatic send(input logic [7:0] b, input logic last, input bit upd);
    int n;
    data_in  = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", 64'(in_ready), 64'd1);
    stall_cycles += n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (upd) model_byte(b, last);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: a transfer happens on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", 64'(data_out), 64'd0);
      end else begin
        word_t w;
        w = sb_q.pop_front();
        chk("word_data", 64'(data_out), 64'(w.data));
        chk("word_keep", 64'(out_keep), 64'(w.keep));
        chk("word_last", 64'(out_last), 64'(w.last));
      end
    end
  end

  initial begin
    rst = 1'b1; data_in = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    model_reset();
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_keep", 64'(out_keep), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Full word, back-to-back, one-cycle latency.
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    chk("lat_before", 64'(out_valid), 64'd0);
    send(8'h44, 1'b0, 1'b1);
    chk("lat_after", 64'(out_valid), 64'd1);
    idle(1);
    chk("valid_fall", 64'(out_valid), 64'd0);

    // Partial word flushed by in_last.
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b1, 1'b1);
    idle(2);

    // Backpressure: word held 5 cycles, next byte waits for out_ready.
    out_ready = 1'b0;
    send(8'h55, 1'b0, 1'b1);
    send(8'h56, 1'b0, 1'b1);
    send(8'h57, 1'b0, 1'b1);
    send(8'h58, 1'b0, 1'b1);
    data_in = 8'h99; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_data", 64'(data_out), 64'h58575655);
      idle(1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_byte(8'h99, 1'b1);
    chk("reload_valid", 64'(out_valid), 64'd1);
    idle(2);

    // Sustained throughput across two words.
    stall_cycles = 0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1);
    chk("no_stall", 64'(stall_cycles), 64'd0);
    idle(2);

    // Last on final lane gives full keep with last set.
    for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), i == 3, 1'b1);
    idle(2);

    // Mid-frame reset discards stale bytes.
    send(8'hD0, 1'b0, 1'b0);
    send(8'hD1, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0, 1'b1);
    idle(2);

`ifdef STREAM_RX_STATS_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_reset();
    chk("stats_rst_words", 64'(word_count), 64'd0);
    chk("stats_rst_frames", 64'(frame_count), 64'd0);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 6; i++) send(8'(16 * f + i), i == 5, 1'b1);
    idle(3);
    chk("stats_words", 64'(word_count), 64'd6);
    chk("stats_frames", 64'(frame_count), 64'd3);
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
